fx_div_seq: RTL and testbench

- Sequential signed fixed-point divider, Q(QINT).(QFRAC) format. Provides the inverse operation to the pipelined multiplier core.
- Computes result = a / b using restoring (shift-subtract) division on magnitudes, then applies sign, saturation and flags.
- Uses the same start/done handshake as the multiplier, so LSM regression datapath stages (e.g. normal-equation solves) can call either operator interchangeably.

---
 rtl/fx_div_seq.sv | 162 ++++++++++++++++
 tb/tb_fx_div_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fx_div_seq.sv
// Sequential signed fixed-point divider, Q(QINT).(QFRAC).
// Restoring shift-subtract division on operand magnitudes produces one
// quotient bit per cycle. A final cycle applies the sign, saturation and
// the divide-by-zero and overflow flags. The start/done handshake matches
// the pipelined multiplier, so either operator can sit behind one wrapper.
module fx_div_seq #(
  parameter int WIDTH = 32,
  parameter int QINT  = 16,
  parameter int QFRAC = WIDTH - QINT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  // Quotient bits produced: the dividend is pre-scaled by 2^QFRAC.
  localparam int N  = WIDTH + QFRAC;
  localparam int CW = $clog2(N);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic             sign_q;   // sign of the true quotient
  logic             a_neg_q;  // dividend sign, selects the divide-by-zero limit
  logic [N-1:0]     num_q;    // scaled dividend magnitude, consumed MSB first
  logic [WIDTH:0]   rem_q;    // partial remainder
  logic [N-1:0]     quo_q;    // magnitude quotient, filled from the LSB
  logic [WIDTH-1:0] bmag_q;   // divisor magnitude
  logic [CW-1:0]    cnt_q;    // iteration counter

  logic [WIDTH-1:0] amag, bmag_in;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             rem_ge;
  logic             last_iter;

  logic [WIDTH-1:0] fin_result;
  logic             fin_dbz, fin_ov;
  logic             pos_ovf, neg_ovf;
  logic [WIDTH-1:0] q_low;

  // Operand magnitudes. The most-negative value maps to 2^(WIDTH-1) exactly.
  always_comb begin
    amag    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    bmag_in = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  // One restoring step: shift in the next dividend bit, then trial-subtract.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], num_q[N-1]};
    rem_ge    = (rem_shift >= {1'b0, bmag_q});
    rem_sub   = rem_shift - {1'b0, bmag_q};
    last_iter = (cnt_q == CW'(N-1));
  end

  // Final result: sign application, saturation and flags.
  always_comb begin
    q_low      = quo_q[WIDTH-1:0];
    pos_ovf    = |quo_q[N-1:WIDTH-1];
    neg_ovf    = (|quo_q[N-1:WIDTH]) | (quo_q[WIDTH-1] & (|quo_q[WIDTH-2:0]));
    fin_result = '0;
    fin_dbz    = 1'b0;
    fin_ov     = 1'b0;
    if (bmag_q == '0) begin
      fin_dbz    = 1'b1;
      fin_result = a_neg_q ? MIN_NEG : MAX_POS;
    end else if (!sign_q && pos_ovf) begin
      fin_ov     = 1'b1;
      fin_result = MAX_POS;
    end else if (sign_q && neg_ovf) begin
      fin_ov     = 1'b1;
      fin_result = MIN_NEG;
    end else begin
      // Negating a zero quotient yields zero, so the result is always +0.
      fin_result = sign_q ? (~q_low + WIDTH'(1)) : q_low;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q      <= 1'b0;
      a_neg_q     <= 1'b0;
      num_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      bmag_q      <= '0;
      cnt_q       <= '0;
      result      <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            a_neg_q <= a[WIDTH-1];
            num_q   <= {amag, {QFRAC{1'b0}}};
            bmag_q  <= bmag_in;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
          end
        end
        CALC: begin
          num_q <= {num_q[N-2:0], 1'b0};
          if (rem_ge) begin
            rem_q <= rem_sub;
            quo_q <= {quo_q[N-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift;
            quo_q <= {quo_q[N-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
        end
        FIN: begin
          result      <= fin_result;
          div_by_zero <= fin_dbz;
          overflow    <= fin_ov;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fx_div_seq.sv
// Scoreboard testbench for fx_div_seq: stimulus pushes hand-computed
// expectations; a monitor pops and compares on every done pulse.
module tb_fx_div_seq;

  localparam int LAT = 50;

  logic        clk, rst, start;
  logic [31:0] a, b, result;
  logic        done, busy, div_by_zero, overflow;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    logic        ov;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks, errors;

  fx_div_seq #(.WIDTH(32), .QINT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .result(result), .done(done), .busy(busy),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d result=%h", cyc, result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || div_by_zero !== e.dbz || overflow !== e.ov) begin
          errors++;
          $display("FAIL %s result=%h dbz=%b ov=%b expected result=%h dbz=%b ov=%b",
                   e.name, result, div_by_zero, overflow, e.res, e.dbz, e.ov);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_latency done_cycle=%0d expected=%0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, expv);
    end
  endtask

  // Issue a one-cycle start; optionally register the expected response.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] er, input logic ed, input logic eo,
                       input string nm, input bit push);
    exp_t e;
    @(posedge clk); #1;
    a = ta; b = tb_v; start = 1'b1;
    e.res = er; e.dbz = ed; e.ov = eo; e.cyc = cyc + LAT; e.name = nm;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout outstanding=%0d", nm, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_flags", {29'b0, done, busy, div_by_zero | overflow}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3.0 / 1.5 with busy profile across the operation
    issue(32'h0003_0000, 32'h0001_8000, 32'h0002_0000, 1'b0, 1'b0, "div_3_by_1p5", 1'b1);
    for (int i = 1; i <= 49; i++) begin
      if (!busy) begin
        checks++; errors++;
        $display("FAIL busy_cycle_%0d got=0 expected=1", i);
      end
      @(posedge clk); #1;
    end
    check("busy_low_at_done", {31'b0, busy}, 32'h0);
    wait_empty("div_3_by_1p5");

    issue(32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0, "neg1_by_3", 1'b1);
    wait_empty("neg1_by_3");
    issue(32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, "neg5_by_0", 1'b1);
    wait_empty("neg5_by_0");
    issue(32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "pos5_by_0", 1'b1);
    wait_empty("pos5_by_0");
    issue(32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, "pos_sat", 1'b1);
    wait_empty("pos_sat");
    issue(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0, "minneg_by_1", 1'b1);
    wait_empty("minneg_by_1");
    issue(32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b1, "neg_sat", 1'b1);
    wait_empty("neg_sat");
    issue(32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, "minneg_by_neg1", 1'b1);
    wait_empty("minneg_by_neg1");
    issue(32'h0001_0000, 32'hFFFE_0000, 32'hFFFF_8000, 1'b0, 1'b0, "one_by_neg2", 1'b1);
    wait_empty("one_by_neg2");
    issue(32'hFFFE_0000, 32'hFFFF_8000, 32'h0004_0000, 1'b0, 1'b0, "neg2_by_neghalf", 1'b1);
    wait_empty("neg2_by_neghalf");
    issue(32'h0000_0000, 32'hFFFD_0000, 32'h0000_0000, 1'b0, 1'b0, "zero_by_neg3", 1'b1);
    wait_empty("zero_by_neg3");

    // start held high: back-to-back operations, one per LAT cycles
    begin
      exp_t e;
      @(posedge clk); #1;
      a = 32'h0006_0000; b = 32'h0002_0000; start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        e.res = 32'h0003_0000; e.dbz = 1'b0; e.ov = 1'b0;
        e.cyc = cyc + k * LAT; e.name = $sformatf("held_start_%0d", k);
        sb.push_back(e);
      end
      repeat (2 * LAT + 1) @(posedge clk);
      #1 start = 1'b0;
      wait_empty("held_start");
    end

    // operand changes and an extra start mid-CALC must not disturb the op
    issue(32'h0003_0000, 32'h0001_8000, 32'h0002_0000, 1'b0, 1'b0, "mid_calc_noise", 1'b1);
    repeat (10) @(posedge clk);
    #1 a = 32'h0007_0000; b = 32'h0000_0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_empty("mid_calc_noise");
    repeat (60) @(posedge clk);
    #1;

    // asynchronous reset at cycle 20 of an operation
    issue(32'h0006_0000, 32'h0002_0000, 32'h0, 1'b0, 1'b0, "aborted", 1'b0);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_busy", {31'b0, busy}, 32'h0);
    check("async_rst_flags", {29'b0, done, div_by_zero, overflow}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    issue(32'h0003_0000, 32'h0001_8000, 32'h0002_0000, 1'b0, 1'b0, "after_reset", 1'b1);
    wait_empty("after_reset");

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
